// File: rtl/key_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_bank
// Description : Conditions NUM_KEYS raw, bouncy, asynchronous key/photo-sensor
//               levels into clean per-note levels for the sound generators.
//               Each input is synchronised by two flops. It is then debounced
//               by a four-state FSM with a stability counter. The results are
//               optionally reduced to a single active note (MONO=1). A
//               one-cycle press strobe carries the index of the key that
//               rose.
// Ports       : clk          system clock
//               rst          asynchronous, active-low reset
//               key_raw      raw key levels, async, 1 = pressed/lit
//               light        debounced (and MONO-masked) key levels
//               press_pulse  1-cycle strobe on any debounced 0->1 change
//               press_code   index of key causing press_pulse (lowest wins),
//                            held between pulses
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_bank #(
    parameter int NUM_KEYS        = 7,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MONO            = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] light,
    output logic                press_pulse,
    output logic [3:0]          press_code
);

    localparam int                 C_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ARM    = 2'd1,
        ST_ON     = 2'd2,
        ST_DISARM = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_deb;
    logic [NUM_KEYS-1:0] w_deb_nxt;
    logic [NUM_KEYS-1:0] w_rise;
    logic [NUM_KEYS-1:0] w_light_nxt;

    // Two-flop synchroniser; only r_sync2 feeds the debounce logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
            state_t             r_state;
            state_t             w_state_nxt;
            logic [C_CNT_W-1:0] r_cnt;
            logic [C_CNT_W-1:0] w_cnt_nxt;
            logic               w_deb_k;

            // The counter leaves ARM/DISARM exactly at its last value, so it
            // never wraps. Any disagreeing sample restarts qualification.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_deb_k     = r_deb[i];
                case (r_state)
                    ST_OFF: begin
                        w_cnt_nxt = '0;
                        if (r_sync2[i]) w_state_nxt = ST_ARM;
                    end
                    ST_ARM: begin
                        if (!r_sync2[i]) begin
                            w_state_nxt = ST_OFF;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == C_CNT_LAST) begin
                            w_state_nxt = ST_ON;
                            w_cnt_nxt   = '0;
                            w_deb_k     = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + C_CNT_W'(1);
                        end
                    end
                    ST_ON: begin
                        w_cnt_nxt = '0;
                        if (!r_sync2[i]) w_state_nxt = ST_DISARM;
                    end
                    ST_DISARM: begin
                        if (r_sync2[i]) begin
                            w_state_nxt = ST_ON;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == C_CNT_LAST) begin
                            w_state_nxt = ST_OFF;
                            w_cnt_nxt   = '0;
                            w_deb_k     = 1'b0;
                        end else begin
                            w_cnt_nxt = r_cnt + C_CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = ST_OFF;
                        w_cnt_nxt   = '0;
                        w_deb_k     = 1'b0;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state <= ST_OFF;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            assign w_deb_nxt[i] = w_deb_k;
        end
    endgenerate

    function automatic logic [3:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (v[k]) idx = 4'(k);
        end
        return idx;
    endfunction

    // Rises are taken before the MONO mask so a press of a masked key is
    // still reported.
    assign w_rise = w_deb_nxt & ~r_deb;

    // x & -x isolates the lowest set bit; yields zero when no key is active.
    always_comb begin
        w_light_nxt = w_deb_nxt;
        if (MONO != 0) w_light_nxt = w_deb_nxt & (~w_deb_nxt + NUM_KEYS'(1));
    end

    // Outputs are registered from the next debounced state so light and
    // press_pulse change on the same edge as the debounced level itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_deb       <= '0;
            light       <= '0;
            press_pulse <= 1'b0;
            press_code  <= 4'd0;
        end else begin
            r_deb       <= w_deb_nxt;
            light       <= w_light_nxt;
            press_pulse <= |w_rise;
            if (|w_rise) press_code <= lowest_idx(w_rise);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_bank
// Description : Directed self-checking bench for key_debounce_bank with
//               DEBOUNCE_CYCLES=4 and NUM_KEYS=7. It holds one instance with
//               MONO=0 and one with MONO=1, both on the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] key_raw = '0;

    logic [6:0] light0;
    logic       pulse0;
    logic [3:0] code0;
    logic [6:0] light1;
    logic       pulse1;
    logic [3:0] code1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    key_debounce_bank #(.NUM_KEYS(7), .DEBOUNCE_CYCLES(4), .MONO(0)) dut0 (
        .clk(clk), .rst(rst), .key_raw(key_raw),
        .light(light0), .press_pulse(pulse0), .press_code(code0)
    );

    key_debounce_bank #(.NUM_KEYS(7), .DEBOUNCE_CYCLES(4), .MONO(1)) dut1 (
        .clk(clk), .rst(rst), .key_raw(key_raw),
        .light(light1), .press_pulse(pulse1), .press_code(code1)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_light0", 32'(light0), 32'h0);
        chk("rst_pulse0", 32'(pulse0), 32'h0);
        chk("rst_code0",  32'(code0),  32'h0);
        chk("rst_light1", 32'(light1), 32'h0);
        rst = 1'b1;
        tick(2);

        // 1: key 2 held; the next edge is edge 0, light rises after edge 6
        key_raw = 7'b0000100;
        tick(6);
        chk("t1_light_e5", 32'(light0), 32'h00);
        chk("t1_pulse_e5", 32'(pulse0), 32'h0);
        tick(1);
        chk("t1_light_e6", 32'(light0), 32'h04);
        chk("t1_pulse_e6", 32'(pulse0), 32'h1);
        chk("t1_code_e6",  32'(code0),  32'h2);
        chk("t1_mono_e6",  32'(light1), 32'h04);
        tick(1);
        chk("t1_pulse_e7", 32'(pulse0), 32'h0);
        chk("t1_code_e7",  32'(code0),  32'h2);
        chk("t1_light_e7", 32'(light0), 32'h04);
        key_raw = 7'b0000000;
        tick(6);
        chk("t1_rel_e5", 32'(light0), 32'h04);
        tick(1);
        chk("t1_rel_e6",   32'(light0), 32'h00);
        chk("t1_rel_puls", 32'(pulse0), 32'h0);

        // 2: key 0 bounces 1,0,1,0 every 2 cycles, then stays low
        for (int p = 0; p < 4; p++) begin
            key_raw = (p % 2 == 0) ? 7'b0000001 : 7'b0000000;
            for (int c = 0; c < 2; c++) begin
                tick(1);
                chk("t2_light0", 32'(light0[0]), 32'h0);
                chk("t2_pulse",  32'(pulse0),    32'h0);
            end
        end
        for (int c = 0; c < 8; c++) begin
            tick(1);
            chk("t2_tail_light0", 32'(light0[0]), 32'h0);
            chk("t2_tail_pulse",  32'(pulse0),    32'h0);
        end

        // 3: key 3 on, then a 3-cycle low glitch
        key_raw = 7'b0001000;
        tick(7);
        chk("t3_on_light", 32'(light0), 32'h08);
        chk("t3_on_pulse", 32'(pulse0), 32'h1);
        chk("t3_on_code",  32'(code0),  32'h3);
        tick(2);
        key_raw = 7'b0000000;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            chk("t3_gl_light", 32'(light0), 32'h08);
            chk("t3_gl_pulse", 32'(pulse0), 32'h0);
        end
        key_raw = 7'b0001000;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            chk("t3_post_light", 32'(light0), 32'h08);
            chk("t3_post_pulse", 32'(pulse0), 32'h0);
        end
        key_raw = 7'b0000000;
        tick(7);
        chk("t3_rel_light", 32'(light0), 32'h00);

        // 4: MONO - keys 1 and 5 held, then key 1 released
        key_raw = 7'b0100010;
        tick(7);
        chk("t4_mono_light", 32'(light1), 32'h02);
        chk("t4_poly_light", 32'(light0), 32'h22);
        chk("t4_pulse",      32'(pulse1), 32'h1);
        chk("t4_code",       32'(code1),  32'h1);
        tick(2);
        key_raw = 7'b0100000;
        tick(6);
        chk("t4_mono_e5", 32'(light1), 32'h02);
        tick(1);
        chk("t4_mono_e6",  32'(light1), 32'h20);
        chk("t4_poly_e6",  32'(light0), 32'h20);
        chk("t4_rel_puls", 32'(pulse1), 32'h0);
        key_raw = 7'b0000000;
        tick(7);
        chk("t4_mono_off", 32'(light1), 32'h00);
        chk("t4_code_hold", 32'(code0), 32'h1);

        // 5: keys 4 and 6 rise on the same edge
        key_raw = 7'b1010000;
        tick(7);
        chk("t5_light", 32'(light0), 32'h50);
        chk("t5_pulse", 32'(pulse0), 32'h1);
        chk("t5_code",  32'(code0),  32'h4);
        chk("t5_mono",  32'(light1), 32'h10);
        tick(1);
        chk("t5_pulse_e7", 32'(pulse0), 32'h0);
        chk("t5_code_e7",  32'(code0),  32'h4);
        key_raw = 7'b0000000;
        tick(7);
        chk("t5_rel", 32'(light0), 32'h00);

        // 6: key 2 in DISARM, reset pulsed, key held through reset
        key_raw = 7'b0000100;
        tick(7);
        chk("t6_on", 32'(light0), 32'h04);
        key_raw = 7'b0000000;
        tick(3);
        chk("t6_disarm_light", 32'(light0), 32'h04);
        rst = 1'b0;
        #1;
        chk("t6_rst_light", 32'(light0), 32'h00);
        chk("t6_rst_code",  32'(code0),  32'h0);
        key_raw = 7'b0000100;
        tick(2);
        chk("t6_rst_hold", 32'(light0), 32'h00);
        rst = 1'b1;
        tick(6);
        chk("t6_e5", 32'(light0), 32'h00);
        tick(1);
        chk("t6_e6_light", 32'(light0), 32'h04);
        chk("t6_e6_pulse", 32'(pulse0), 32'h1);
        chk("t6_e6_code",  32'(code0),  32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
